// File: rtl/cdb_arbiter_if.sv
// Bundle of the reservation-station result ports and the CDB broadcast port.
// The arbiter connects through the slave modport; the producers/consumer use master.
interface cdb_arbiter_if #(
    parameter int N_REQ          = 4,
    parameter int XLEN           = 64,
    parameter int ROB_IDX_LEN    = 6,
    parameter int ROB_EXCEPT_LEN = 5,
    parameter int SRC_W          = $clog2(N_REQ)
);
    // Handshake: a result moves on a cycle where valid and ready are both high.
    // A producer holds valid and payload stable until it sees ready; ready never
    // depends on anything the producer changes in response to ready.
    logic [N_REQ-1:0]                     rs_valid_i;
    logic [N_REQ-1:0]                     rs_ready_o;
    logic [N_REQ-1:0][ROB_IDX_LEN-1:0]    rs_idx_i;
    logic [N_REQ-1:0][XLEN-1:0]           rs_data_i;
    logic [N_REQ-1:0]                     rs_except_raised_i;
    logic [N_REQ-1:0][ROB_EXCEPT_LEN-1:0] rs_except_i;
    logic                                 rob_ready_i;
    logic                                 cdb_valid_o;
    logic [ROB_IDX_LEN-1:0]               cdb_idx_o;
    logic [XLEN-1:0]                      cdb_data_o;
    logic                                 cdb_except_raised_o;
    logic [ROB_EXCEPT_LEN-1:0]            cdb_except_o;
    logic [SRC_W-1:0]                     cdb_src_o;

    modport slave (
        input  rs_valid_i, rs_idx_i, rs_data_i, rs_except_raised_i, rs_except_i, rob_ready_i,
        output rs_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o,
               cdb_except_o, cdb_src_o
    );

    modport master (
        output rs_valid_i, rs_idx_i, rs_data_i, rs_except_raised_i, rs_except_i, rob_ready_i,
        input  rs_ready_o, cdb_valid_o, cdb_idx_o, cdb_data_o, cdb_except_raised_o,
               cdb_except_o, cdb_src_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one reservation station per cycle onto the CDB.
// Define CDB_ARB_OUT_REG_EN for a registered output stage; otherwise the CDB is a combinational bypass.
module cdb_arbiter #(
    parameter int N_REQ          = 4,
    parameter int XLEN           = 64,
    parameter int ROB_IDX_LEN    = 6,
    parameter int ROB_EXCEPT_LEN = 5,
    parameter int SRC_W          = $clog2(N_REQ)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);
    logic [SRC_W-1:0] rr_q;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] cand;
    logic             found;
    logic             slot_free;
    logic             accept;
    int               idx;

    // First valid requester at or after rr_q, wrapping modulo N_REQ (N_REQ need not be 2^k).
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = SRC_W'(idx);
            if (!found && bus.rs_valid_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign accept = found && slot_free && !flush_i && !rst_i;

    always_comb begin
        bus.rs_ready_o = '0;
        if (accept) bus.rs_ready_o[grant] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (accept) begin
            rr_q <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

`ifdef CDB_ARB_OUT_REG_EN
    logic                      out_valid_q;
    logic [ROB_IDX_LEN-1:0]    out_idx_q;
    logic [XLEN-1:0]           out_data_q;
    logic                      out_except_raised_q;
    logic [ROB_EXCEPT_LEN-1:0] out_except_q;
    logic [SRC_W-1:0]          out_src_q;

    // The slot can be refilled on the same edge the ROB drains it.
    assign slot_free = !out_valid_q || bus.rob_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q         <= 1'b0;
            out_idx_q           <= '0;
            out_data_q          <= '0;
            out_except_raised_q <= 1'b0;
            out_except_q        <= '0;
            out_src_q           <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q         <= 1'b1;
            out_idx_q           <= bus.rs_idx_i[grant];
            out_data_q          <= bus.rs_data_i[grant];
            out_except_raised_q <= bus.rs_except_raised_i[grant];
            out_except_q        <= bus.rs_except_i[grant];
            out_src_q           <= grant;
        end else if (bus.rob_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.cdb_valid_o         = out_valid_q;
    assign bus.cdb_idx_o           = out_idx_q;
    assign bus.cdb_data_o          = out_data_q;
    assign bus.cdb_except_raised_o = out_except_raised_q;
    assign bus.cdb_except_o        = out_except_q;
    assign bus.cdb_src_o           = out_src_q;
`else
    assign slot_free = bus.rob_ready_i;

    assign bus.cdb_valid_o         = found && !flush_i && !rst_i;
    assign bus.cdb_idx_o           = found ? bus.rs_idx_i[grant] : '0;
    assign bus.cdb_data_o          = found ? bus.rs_data_i[grant] : '0;
    assign bus.cdb_except_raised_o = found ? bus.rs_except_raised_i[grant] : 1'b0;
    assign bus.cdb_except_o        = found ? bus.rs_except_i[grant] : '0;
    assign bus.cdb_src_o           = found ? grant : '0;
`endif
endmodule
